// File: rtl/pc_fetch_sequencer_if.sv
// Instruction-memory request/acknowledge bus between the fetch sequencer
// (master) and instruction memory (slave).
interface pc_fetch_sequencer_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  imem_req;
    logic [DATA_WIDTH-1:0] imem_addr;
    logic                  imem_ack;
    logic [DATA_WIDTH-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// Fetch-side controller: owns the PC, fetches one instruction at a time over
// a req/ack bus, holds it for decode under stall, then advances the PC by +4
// or by a branch immediate. Redirects (trap/flush) override everything except
// the single post-reset boot cycle; misaligned targets park the block in FAULT.
//
// state | meaning
// BOOT  | one idle cycle after reset release, no request
// FETCH | imem_req=1 at PC, waiting for imem_ack
// ISSUE | instruction held for decode, waiting for stall=0
// FAULT | misaligned target trapped, fetch halted until redirect
module pc_fetch_sequencer #(
    parameter int                        DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0]     RESET_VECTOR = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  PCsrc,
    input  logic [DATA_WIDTH-1:0] ImmOp,
    input  logic                  redirect,
    input  logic [DATA_WIDTH-1:0] redirect_addr,
    pc_fetch_sequencer_if.master  imem,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [DATA_WIDTH-1:0] instr_pc,
    output logic                  instr_valid,
    output logic [DATA_WIDTH-1:0] PC,
    output logic                  fault
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2,
        FAULT = 2'd3
    } state_t;

    state_t                state_q;
    logic [DATA_WIDTH-1:0] pc_q;
    logic [DATA_WIDTH-1:0] instr_q;
    logic [DATA_WIDTH-1:0] instr_pc_q;
    logic                  valid_q;
    logic                  fault_q;
    logic                  req_q;
    logic [DATA_WIDTH-1:0] next_pc_d;

    // Consume target: branch offset or sequential step, both modulo 2^DATA_WIDTH.
    always_comb begin
        next_pc_d = '0;
        if (PCsrc) begin
            next_pc_d = instr_pc_q + ImmOp;
        end else begin
            next_pc_d = instr_pc_q + DATA_WIDTH'(4);
        end
    end

    // Sequencer FSM with registered outputs; redirect has priority outside BOOT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= BOOT;
            pc_q       <= RESET_VECTOR;
            instr_q    <= '0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
            fault_q    <= 1'b0;
            req_q      <= 1'b0;
        end else if (state_q == BOOT) begin
            state_q <= FETCH;
            req_q   <= 1'b1;
        end else if (redirect) begin
            // Any same-cycle ack or consume is dropped; the target is trapped
            // if it is not word aligned.
            pc_q    <= redirect_addr;
            valid_q <= 1'b0;
            if (redirect_addr[1:0] != 2'b00) begin
                fault_q <= 1'b1;
                req_q   <= 1'b0;
                state_q <= FAULT;
            end else begin
                fault_q <= 1'b0;
                req_q   <= 1'b1;
                state_q <= FETCH;
            end
        end else begin
            case (state_q)
                FETCH: begin
                    if (imem.imem_ack) begin
                        instr_q    <= imem.imem_rdata;
                        instr_pc_q <= pc_q;
                        valid_q    <= 1'b1;
                        req_q      <= 1'b0;
                        state_q    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!stall) begin
                        valid_q <= 1'b0;
                        if (next_pc_d[1:0] == 2'b00) begin
                            pc_q    <= next_pc_d;
                            req_q   <= 1'b1;
                            state_q <= FETCH;
                        end else begin
                            fault_q <= 1'b1;
                            state_q <= FAULT;
                        end
                    end
                end
                default: begin
                    // FAULT holds until a redirect or reset.
                end
            endcase
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc_q;
    assign instr          = instr_q;
    assign instr_pc       = instr_pc_q;
    assign instr_valid    = valid_q;
    assign PC             = pc_q;
    assign fault          = fault_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed walk through the fetch scenarios followed by a randomized run, all
// compared against a flag-based reference model of the fetch rules.
module tb_pc_fetch_sequencer;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        PCsrc;
    logic [31:0] ImmOp;
    logic        redirect;
    logic [31:0] redirect_addr;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic [31:0] PC;
    logic        fault;

    pc_fetch_sequencer_if #(.DATA_WIDTH(32)) imem_if ();

    pc_fetch_sequencer #(
        .DATA_WIDTH   (32),
        .RESET_VECTOR (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .PCsrc         (PCsrc),
        .ImmOp         (ImmOp),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .imem          (imem_if.master),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_valid   (instr_valid),
        .PC            (PC),
        .fault         (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: what the fetch unit is holding, expressed as flags.
    logic [31:0] m_pc, m_instr, m_ipc;
    bit          m_valid, m_fault, m_boot;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc    = 32'h0;
        m_instr = 32'h0;
        m_ipc   = 32'h0;
        m_valid = 0;
        m_fault = 0;
        m_boot  = 1;
    endtask

    // Apply the fetch rules to the inputs present at this clock edge.
    task automatic model_edge();
        logic [31:0] nxt;
        if (m_boot) begin
            m_boot = 0;
        end else if (redirect) begin
            m_pc    = redirect_addr;
            m_valid = 0;
            m_fault = (redirect_addr % 4) != 0;
        end else if (m_fault) begin
        end else if (!m_valid) begin
            if (imem_if.imem_ack) begin
                m_instr = imem_if.imem_rdata;
                m_ipc   = m_pc;
                m_valid = 1;
            end
        end else if (!stall) begin
            nxt     = PCsrc ? m_ipc + ImmOp : m_ipc + 32'd4;
            m_valid = 0;
            if (nxt % 4 == 0) m_pc = nxt;
            else              m_fault = 1;
        end
    endtask

    task automatic compare_all(input string ph);
        logic exp_req;
        exp_req = !m_boot && !m_valid && !m_fault;
        chk({ph, "_req"},   {31'd0, imem_if.imem_req}, {31'd0, exp_req});
        chk({ph, "_addr"},  imem_if.imem_addr, m_pc);
        chk({ph, "_pc"},    PC, m_pc);
        chk({ph, "_valid"}, {31'd0, instr_valid}, {31'd0, m_valid});
        chk({ph, "_fault"}, {31'd0, fault}, {31'd0, m_fault});
        chk({ph, "_instr"}, instr, m_instr);
        chk({ph, "_ipc"},   instr_pc, m_ipc);
    endtask

    task automatic cycle(input string ph);
        @(posedge clk);
        model_edge();
        #1;
        compare_all(ph);
    endtask

    task automatic idle_inputs();
        stall              = 1'b0;
        PCsrc              = 1'b0;
        ImmOp              = 32'h0;
        redirect           = 1'b0;
        redirect_addr      = 32'h0;
        imem_if.imem_ack   = 1'b0;
        imem_if.imem_rdata = 32'h0;
    endtask

    task automatic do_redirect(input logic [31:0] a, input string ph);
        redirect = 1'b1; redirect_addr = a;
        cycle(ph);
        redirect = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        model_reset();
        #2;
        compare_all("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Boot: ack always high, one idle cycle then fetch at 0.
        imem_if.imem_ack = 1'b1; imem_if.imem_rdata = 32'hA000_0001;
        #1 compare_all("boot");
        chk("boot_req_low", {31'd0, imem_if.imem_req}, 32'd0);
        cycle("boot_exit");
        chk("first_fetch_addr", imem_if.imem_addr, 32'h0);
        chk("first_fetch_req", {31'd0, imem_if.imem_req}, 32'd1);
        stall = 1'b1;
        cycle("first_capture");
        chk("first_ipc", instr_pc, 32'h0);
        chk("first_instr", instr, 32'hA000_0001);

        // Stall holds the instruction for three cycles.
        imem_if.imem_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) cycle("stall_hold");
        chk("stall_instr_held", instr, 32'hA000_0001);
        stall = 1'b0;
        cycle("consume0");
        chk("seq_addr4", imem_if.imem_addr, 32'h4);
        imem_if.imem_rdata = 32'hA000_0002;
        cycle("fetch1");
        cycle("consume1");
        chk("seq_addr8", imem_if.imem_addr, 32'h8);

        // Backward branch from 0x10.
        imem_if.imem_ack = 1'b0;
        do_redirect(32'h10, "redir10");
        imem_if.imem_ack = 1'b1; imem_if.imem_rdata = 32'hB000_0000;
        cycle("fetch10");
        PCsrc = 1'b1; ImmOp = 32'hFFFF_FFF8;
        cycle("branch_back");
        chk("branch_addr8", imem_if.imem_addr, 32'h8);

        // Misaligned branch target traps.
        imem_if.imem_ack = 1'b0;
        do_redirect(32'h10, "redir10b");
        imem_if.imem_ack = 1'b1;
        cycle("fetch10b");
        ImmOp = 32'h6;
        cycle("branch_mis");
        chk("mis_fault", {31'd0, fault}, 32'd1);
        chk("mis_pc", PC, 32'h10);
        PCsrc = 1'b0; ImmOp = 32'h0;
        cycle("fault_stay");

        // Redirect leaves FAULT.
        imem_if.imem_ack = 1'b0;
        do_redirect(32'h200, "redir_fault");
        chk("fault_cleared", {31'd0, fault}, 32'd0);
        chk("resume_addr", imem_if.imem_addr, 32'h200);

        // Memory wait: four cycles without ack, then capture.
        for (int i = 0; i < 4; i++) cycle("mem_wait");
        chk("wait_valid_low", {31'd0, instr_valid}, 32'd0);
        imem_if.imem_ack = 1'b1; imem_if.imem_rdata = 32'hC0DE_0200;
        cycle("wait_ack");
        chk("wait_capture", instr, 32'hC0DE_0200);
        cycle("wait_consume");

        // Redirect colliding with ack drops the returned word.
        imem_if.imem_rdata = 32'h1111_2222;
        do_redirect(32'h200, "redir_ack");
        chk("collide_valid", {31'd0, instr_valid}, 32'd0);
        chk("collide_addr", imem_if.imem_addr, 32'h200);

        // Redirect colliding with a consume drops the branch.
        cycle("fetch_c");
        PCsrc = 1'b1; ImmOp = 32'h100;
        do_redirect(32'h40, "redir_consume");
        chk("consume_drop_addr", imem_if.imem_addr, 32'h40);
        PCsrc = 1'b0; ImmOp = 32'h0;

        // Sequential wrap at the top of the address space.
        do_redirect(32'hFFFF_FFFC, "redir_top");
        cycle("fetch_top");
        cycle("consume_top");
        chk("wrap_addr", imem_if.imem_addr, 32'h0);
        chk("wrap_fault", {31'd0, fault}, 32'd0);

        // Misaligned redirect traps directly.
        imem_if.imem_ack = 1'b0;
        do_redirect(32'h0000_0102, "redir_mis");
        chk("redir_mis_fault", {31'd0, fault}, 32'd1);
        do_redirect(32'h80, "redir_out");

        // Async reset mid-fetch.
        #3;
        rst = 1'b0;
        model_reset();
        #1;
        chk("async_req", {31'd0, imem_if.imem_req}, 32'd0);
        chk("async_pc", PC, 32'h0);
        compare_all("async");
        @(negedge clk);
        rst = 1'b1;
        imem_if.imem_ack = 1'b1;
        do_redirect(32'h300, "boot_redirect_ignored");
        cycle("post_boot");

        // Randomized run.
        for (int i = 0; i < 3000; i++) begin
            stall              = ($urandom_range(0, 2) == 0);
            imem_if.imem_ack   = ($urandom_range(0, 1) == 1);
            imem_if.imem_rdata = $urandom;
            PCsrc              = ($urandom_range(0, 1) == 1);
            ImmOp              = 32'($signed($urandom_range(0, 128)) - 64);
            if ($urandom_range(0, 4) != 0) ImmOp = ImmOp & 32'hFFFF_FFFC;
            redirect           = ($urandom_range(0, 15) == 0);
            redirect_addr      = $urandom;
            if ($urandom_range(0, 3) != 0) redirect_addr = redirect_addr & 32'hFFFF_FFFC;
            cycle("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
